// File: rtl/bram_in_arbiter.sv
// Round-robin arbiter/sequencer for a shared BRAM write port: grants whole bursts,
// drives the external input-mux select, write enable and address, with an idle timeout.
module bram_in_arbiter #(
  parameter int unsigned NUM_REQ = 6,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [SEL_W-1:0]          mux_sel,
  output logic                      bram_we,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic                      busy,
  output logic                      timeout_evt
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  owner_q, owner_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   idle_cnt_q, idle_cnt_d;
  logic              tevt_q, tevt_d;

  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W-1:0]  next_ptr;
  logic              owner_valid;
  logic              owner_last;

  function automatic logic [SEL_W-1:0] rr_idx(logic [SEL_W-1:0] base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SEL_W'(s);
  endfunction

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[rr_idx(rr_ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(rr_ptr_q, k);
      end
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign next_ptr    = (owner_q == SEL_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    tevt_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          idle_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (owner_valid) begin
          idle_cnt_d = '0;
          if (owner_last) begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
          end
        end else if (TIMEOUT != 0 && idle_cnt_q == CntLast) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
          tevt_d   = 1'b1;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      tevt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      tevt_q     <= tevt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StGrant) req_ready[owner_q] = 1'b1;
  end

  assign busy        = (state_q == StGrant);
  assign mux_sel     = owner_q;
  assign timeout_evt = tevt_q;
  // Reset abandons the burst, so the beat presented on the reset edge must not land.
  assign bram_we     = busy & owner_valid & ~rst;
  assign bram_addr   = busy ? req_addr[owner_q*ADDR_W +: ADDR_W] : '0;

endmodule
